// File: rtl/ad9957_spi_ctl_pkg.sv
// ---------------------------------------------------------------------------
// ad9957_spi_ctl_pkg
// Shared definitions for the AD9957 serial-port controller:
//   - controller state enumeration
//   - instruction-byte field positions and width
//   - maximum data length in bytes
//   - helpers that normalise the byte count and assemble the instruction byte
// ---------------------------------------------------------------------------
package ad9957_spi_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INSTR = 3'd1,
      ST_DATA  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_UPD   = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   localparam int INSTR_BITS     = 8;
   localparam int INSTR_RW_BIT   = 7;
   localparam int INSTR_ADDR_MSB = 4;
   localparam int INSTR_ADDR_LSB = 0;
   localparam int MAX_LEN        = 8;

   // Byte count minus one; out-of-range counts (0 or above MAX_LEN) mean MAX_LEN.
   function automatic logic [2:0] len_m1(input logic [3:0] len);
      if ((len == 4'd0) || (len > 4'(MAX_LEN))) begin
         return 3'd7;
      end else begin
         return 3'(len - 4'd1);
      end
   endfunction

   // Instruction byte: {rw, 2'b00, addr}.
   function automatic logic [7:0] make_instr(input logic rw, input logic [4:0] addr);
      logic [7:0] v;
      v = 8'd0;
      v[INSTR_RW_BIT] = rw;
      v[INSTR_ADDR_MSB:INSTR_ADDR_LSB] = addr;
      return v;
   endfunction

endpackage

// File: rtl/ad9957_spi_clkgen.sv
// ---------------------------------------------------------------------------
// ad9957_spi_clkgen
// Half-period counter producing SCLK edge strobes. Each HALF_DIV enabled clk
// cycles one strobe fires, alternating rise/fall, starting with a rise after
// a clear.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   i_en         count enable
//   i_clr        synchronous clear (counter and phase back to "before rise")
//   o_rise       strobe: SCLK goes high at this clk edge
//   o_fall       strobe: SCLK goes low at this clk edge
// ---------------------------------------------------------------------------
module ad9957_spi_clkgen #(
   parameter int HALF_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_rise,
   output logic o_fall
);

   logic [7:0] r_cnt;
   logic       r_ph;      // 0: next strobe is a rise, 1: next strobe is a fall
   logic       w_tc;

   assign w_tc   = i_en && (r_cnt == 8'(HALF_DIV - 1));
   assign o_rise = w_tc && !r_ph;
   assign o_fall = w_tc && r_ph;

   // Half-period counter and SCLK phase tracker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 8'd0;
         r_ph  <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= 8'd0;
         r_ph  <= 1'b0;
      end else if (w_tc) begin
         r_cnt <= 8'd0;
         r_ph  <= ~r_ph;
      end else if (i_en) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/ad9957_spi_ctl.sv
// ---------------------------------------------------------------------------
// ad9957_spi_ctl
// Command-driven SPI master for the AD9957 DDS serial port. A command sends
// the instruction byte {rw,2'b00,addr} followed by 1..8 data bytes MSB first,
// optionally followed by an IO_UPDATE strobe (writes only), then a CSB gap.
// Optional feature: define AD9957_SPI_READBACK_EN to enable reads (sdio
// turnaround and rsp_* result). Without it every command is a write,
// sdio_oe is tied high, rsp_* are tied low and sdio_i is ignored.
// Ports:
//   clk, rst_n                     system clock, async active-low reset
//   cmd_vld/cmd_rdy                command handshake (rdy == IDLE)
//   cmd_rw,addr,len,data,upd       command fields, latched on acceptance
//   rsp_vld/rsp_data               read result (1-cycle pulse, data held)
//   busy                           transaction in progress
//   sclk,csb,sdio_o,sdio_oe,sdio_i DDS serial port
//   io_upd                         IO_UPDATE strobe
// ---------------------------------------------------------------------------
module ad9957_spi_ctl
   import ad9957_spi_ctl_pkg::*;
#(
   parameter int HALF_DIV = 4,
   parameter int CS_GAP   = 8,
   parameter int UPD_LEN  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic        cmd_rw,
   input  logic [4:0]  cmd_addr,
   input  logic [3:0]  cmd_len,
   input  logic [63:0] cmd_data,
   input  logic        cmd_upd,
   output logic        rsp_vld,
   output logic [63:0] rsp_data,
   output logic        busy,
   output logic        sclk,
   output logic        csb,
   output logic        sdio_o,
   output logic        sdio_oe,
   input  logic        sdio_i,
   output logic        io_upd
);

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_rw;
   logic        r_upd;
   logic [4:0]  r_addr;
   logic [2:0]  r_lenm1;
   logic [63:0] r_sh;
   logic [6:0]  r_bit;
   logic [7:0]  r_wait;
   logic        r_csb;
   logic        r_sclk;
   logic        r_sdio_o;
   logic        r_oe;
   logic        r_io_upd;
   logic        r_rsp_vld;
   logic [63:0] r_rsp_data;

   logic        w_cmd_rw;
   logic        w_sdio_i;
   logic [2:0]  w_lenm1_in;
   logic [5:0]  w_ld_sh;
   logic [7:0]  w_instr_in;
   logic [7:0]  w_instr;
   logic [5:0]  w_last_bit;
   logic        w_en;
   logic        w_rise;
   logic        w_fall;

`ifdef AD9957_SPI_READBACK_EN
   assign w_cmd_rw = cmd_rw;
   assign w_sdio_i = sdio_i;
   assign sdio_oe  = r_oe;
   assign rsp_vld  = r_rsp_vld;
   assign rsp_data = r_rsp_data;
`else
   logic w_unused;
   assign w_cmd_rw = 1'b0;
   assign w_sdio_i = 1'b0;
   assign sdio_oe  = 1'b1;
   assign rsp_vld  = 1'b0;
   assign rsp_data = 64'd0;
   assign w_unused = ^{cmd_rw, sdio_i, r_oe, r_rsp_vld, r_rsp_data};
`endif

   assign cmd_rdy    = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign csb        = r_csb;
   assign sclk       = r_sclk;
   assign sdio_o     = r_sdio_o;
   assign io_upd     = r_io_upd;

   assign w_lenm1_in = len_m1(cmd_len);
   // Left-justify the write data so the first byte to send sits at bit 63.
   assign w_ld_sh    = {3'd7 - w_lenm1_in, 3'b000};
   assign w_instr_in = make_instr(w_cmd_rw, cmd_addr);
   assign w_instr    = make_instr(r_rw, r_addr);
   assign w_last_bit = {r_lenm1, 3'b111};

   // The SCLK generator runs only while CSB is low; otherwise it is held cleared.
   assign w_en = (r_state == ST_INSTR) || (r_state == ST_DATA) || (r_state == ST_HOLD);

   ad9957_spi_clkgen #(
      .HALF_DIV (HALF_DIV)
   ) u_clkgen (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_en),
      .i_clr  (!w_en),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (cmd_vld) w_state_nxt = ST_INSTR;
            else         w_state_nxt = ST_IDLE;
         end
         ST_INSTR: begin
            if (w_fall && (r_bit == 7'(INSTR_BITS - 1))) w_state_nxt = ST_DATA;
            else                                          w_state_nxt = ST_INSTR;
         end
         ST_DATA: begin
            if (w_fall && (r_bit == {1'b0, w_last_bit})) w_state_nxt = ST_HOLD;
            else                                          w_state_nxt = ST_DATA;
         end
         ST_HOLD: begin
            // The would-be rise instant marks the end of the CSB hold half-period.
            if (w_rise) begin
               if (r_upd && !r_rw) w_state_nxt = ST_UPD;
               else                w_state_nxt = ST_GAP;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_UPD: begin
            if (r_wait == 8'(UPD_LEN - 1)) w_state_nxt = ST_GAP;
            else                           w_state_nxt = ST_UPD;
         end
         ST_GAP: begin
            if (r_wait == 8'(CS_GAP - 1)) w_state_nxt = ST_IDLE;
            else                          w_state_nxt = ST_GAP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: command latch, shift register, bit/wait counters and port outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rw       <= 1'b0;
         r_upd      <= 1'b0;
         r_addr     <= 5'd0;
         r_lenm1    <= 3'd0;
         r_sh       <= 64'd0;
         r_bit      <= 7'd0;
         r_wait     <= 8'd0;
         r_csb      <= 1'b1;
         r_sclk     <= 1'b0;
         r_sdio_o   <= 1'b0;
         r_oe       <= 1'b1;
         r_io_upd   <= 1'b0;
         r_rsp_vld  <= 1'b0;
         r_rsp_data <= 64'd0;
      end else begin
         r_rsp_vld <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_vld) begin
                  r_rw     <= w_cmd_rw;
                  r_upd    <= cmd_upd;
                  r_addr   <= cmd_addr;
                  r_lenm1  <= w_lenm1_in;
                  r_sh     <= w_cmd_rw ? 64'd0 : (cmd_data << w_ld_sh);
                  r_bit    <= 7'd0;
                  r_csb    <= 1'b0;
                  r_sdio_o <= w_instr_in[INSTR_BITS-1];
               end
            end
            ST_INSTR: begin
               if (w_rise) r_sclk <= 1'b1;
               if (w_fall) begin
                  r_sclk <= 1'b0;
                  if (r_bit == 7'(INSTR_BITS - 1)) begin
                     r_bit    <= 7'd0;
                     r_sdio_o <= r_rw ? 1'b0 : r_sh[63];
                     r_oe     <= !r_rw;
                  end else begin
                     r_bit    <= r_bit + 7'd1;
                     r_sdio_o <= w_instr[3'd6 - r_bit[2:0]];
                  end
               end
            end
            ST_DATA: begin
               if (w_rise) begin
                  r_sclk <= 1'b1;
                  // Reads shift in at the LSB so the result ends right-justified.
                  if (r_rw) r_sh <= {r_sh[62:0], w_sdio_i};
               end
               if (w_fall) begin
                  r_sclk <= 1'b0;
                  if (r_bit == {1'b0, w_last_bit}) begin
                     r_sdio_o <= 1'b0;
                     r_oe     <= 1'b1;
                  end else begin
                     r_bit <= r_bit + 7'd1;
                     if (!r_rw) begin
                        r_sh     <= r_sh << 1;
                        r_sdio_o <= r_sh[62];
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (w_rise) begin
                  r_csb  <= 1'b1;
                  r_wait <= 8'd0;
                  if (r_upd && !r_rw) r_io_upd <= 1'b1;
                  if (r_rw) begin
                     r_rsp_vld  <= 1'b1;
                     r_rsp_data <= r_sh;
                  end
               end
            end
            ST_UPD: begin
               if (r_wait == 8'(UPD_LEN - 1)) begin
                  r_io_upd <= 1'b0;
                  r_wait   <= 8'd0;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            ST_GAP: begin
               r_wait <= r_wait + 8'd1;
            end
            default: begin
               r_csb  <= 1'b1;
               r_sclk <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ad9957_spi_ctl.sv
// ---------------------------------------------------------------------------
// tb_ad9957_spi_ctl
// Directed bench for ad9957_spi_ctl with default parameters. A negedge
// monitor counts SCLK rises, captures sdio_o MSB first, tracks io_upd, CSB
// gap length and rsp_vld, and models the DDS read driver on sdio_i.
// Expectations follow the AD9957_SPI_READBACK_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_ad9957_spi_ctl;

   localparam int HALF_DIV = 4;
   localparam int CS_GAP   = 8;
   localparam int UPD_LEN  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_vld = 1'b0;
   logic        cmd_rdy;
   logic        cmd_rw = 1'b0;
   logic [4:0]  cmd_addr = 5'd0;
   logic [3:0]  cmd_len = 4'd1;
   logic [63:0] cmd_data = 64'd0;
   logic        cmd_upd = 1'b0;
   logic        rsp_vld;
   logic [63:0] rsp_data;
   logic        busy;
   logic        sclk;
   logic        csb;
   logic        sdio_o;
   logic        sdio_oe;
   logic        sdio_i = 1'b0;
   logic        io_upd;

   int n_chk = 0;
   int n_bad = 0;

   // monitor state
   int           rise_cnt = 0, fall_cnt = 0, oe_low = 0;
   int           upd_cyc = 0, upd_pulses = 0, upd_err = 0;
   int           rsp_cnt = 0, hi_cnt = 0, last_hi = 0, hw = 0;
   int           w_bad = 0, rdy_bad = 0, sclk_bad = 0;
   logic [127:0] cap = 128'd0;
   logic [63:0]  rsp_val = 64'd0;
   logic [31:0]  rdval = 32'h0040_0820;
   logic         prev_csb = 1'b1, prev_sclk = 1'b0, prev_upd = 1'b0;

   ad9957_spi_ctl #(
      .HALF_DIV (HALF_DIV),
      .CS_GAP   (CS_GAP),
      .UPD_LEN  (UPD_LEN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .cmd_rw   (cmd_rw),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .cmd_data (cmd_data),
      .cmd_upd  (cmd_upd),
      .rsp_vld  (rsp_vld),
      .rsp_data (rsp_data),
      .busy     (busy),
      .sclk     (sclk),
      .csb      (csb),
      .sdio_o   (sdio_o),
      .sdio_oe  (sdio_oe),
      .sdio_i   (sdio_i),
      .io_upd   (io_upd)
   );

   always #5 clk = ~clk;

   // Bus monitor and DDS read-data model, sampled away from the active edge.
   always @(negedge clk) begin
      if (!csb && prev_csb) begin
         last_hi = hi_cnt; hi_cnt = 0;
         rise_cnt = 0; fall_cnt = 0; cap = 128'd0; oe_low = 0;
         upd_cyc = 0; upd_pulses = 0; rsp_cnt = 0;
      end else if (csb) begin
         hi_cnt++;
      end
      if (sclk && !prev_sclk) begin
         rise_cnt++;
         cap = {cap[126:0], sdio_o};
         if (!sdio_oe) oe_low++;
      end
      if (sclk) hw++;
      if (!sclk && prev_sclk) begin
         fall_cnt++;
         if (hw != HALF_DIV) w_bad++;
         hw = 0;
         if (fall_cnt >= 8 && fall_cnt < 40) sdio_i = rdval[39 - fall_cnt];
         else sdio_i = 1'b0;
      end
      if (io_upd) begin
         upd_cyc++;
         if (!prev_upd) upd_pulses++;
         if (!csb) upd_err++;
      end
      if (rsp_vld) begin
         rsp_cnt++;
         rsp_val = rsp_data;
      end
      if (cmd_rdy && (busy || !csb)) rdy_bad++;
      if (csb && sclk) sclk_bad++;
      prev_csb = csb; prev_sclk = sclk; prev_upd = io_upd;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present a command, wait (bounded) for acceptance, then scramble the fields.
   task automatic send(input logic rw, input logic [4:0] addr, input logic [3:0] len,
                       input logic [63:0] data, input logic upd);
      int n;
      @(negedge clk);
      cmd_rw = rw; cmd_addr = addr; cmd_len = len; cmd_data = data; cmd_upd = upd;
      cmd_vld = 1'b1;
      n = 0;
      while (!cmd_rdy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("accept_rdy", 64'(cmd_rdy), 64'd1);
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
      cmd_rw = ~rw; cmd_addr = 5'h1F; cmd_len = 4'd3; cmd_upd = ~upd;
      cmd_data = {$urandom, $urandom};
      @(negedge clk);
      check("csb_low_after_acc", 64'(csb), 64'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("idle_reached", 64'(busy), 64'd0);
   endtask

   initial begin
      // ---- reset values ----
      repeat (3) @(negedge clk);
      check("rst_csb", 64'(csb), 64'd1);
      check("rst_sclk", 64'(sclk), 64'd0);
      check("rst_sdio", {62'd0, sdio_o, sdio_oe}, 64'd1);
      check("rst_upd_vld_busy", {61'd0, io_upd, rsp_vld, busy}, 64'd0);
      check("rst_rsp_data", rsp_data, 64'd0);
      check("rst_rdy", 64'(cmd_rdy), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- full-length write with IO_UPDATE ----
      send(1'b0, 5'h0E, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b1);
      wait_idle();
      check("w8_rises", 64'(rise_cnt), 64'd72);
      check("w8_instr", cap[71:64], 64'h0E);
      check("w8_data", cap[63:0], 64'h0123_4567_89AB_CDEF);
      check("w8_upd_pulses", 64'(upd_pulses), 64'd1);
      check("w8_upd_cycles", 64'(upd_cyc), 64'd4);
      check("w8_oe_low", 64'(oe_low), 64'd0);
      check("w8_rsp", 64'(rsp_cnt), 64'd0);
      check("sclk_half_width", 64'(w_bad), 64'd0);

      // ---- read, addr 0, 4 bytes (upd set: must be ignored for real reads) ----
      send(1'b1, 5'h00, 4'd4, 64'd0, 1'b1);
      wait_idle();
      check("rd_rises", 64'(rise_cnt), 64'd40);
`ifdef AD9957_SPI_READBACK_EN
      check("rd_instr", cap[39:32], 64'h80);
      check("rd_oe_low", 64'(oe_low), 64'd32);
      check("rd_rsp_cnt", 64'(rsp_cnt), 64'd1);
      check("rd_rsp_val", rsp_val, 64'h0040_0820);
      check("rd_upd_pulses", 64'(upd_pulses), 64'd0);
`else
      check("rd_instr", cap[39:32], 64'h00);
      check("rd_oe_low", 64'(oe_low), 64'd0);
      check("rd_rsp_cnt", 64'(rsp_cnt), 64'd0);
      check("rd_rsp_data", rsp_data, 64'd0);
      check("rd_upd_pulses", 64'(upd_pulses), 64'd1);
`endif

      // ---- back-to-back with cmd_vld held ----
      @(negedge clk);
      cmd_rw = 1'b0; cmd_addr = 5'h03; cmd_len = 4'd1; cmd_data = 64'h5A; cmd_upd = 1'b0;
      cmd_vld = 1'b1;
      @(posedge clk);
      #1;
      cmd_addr = 5'h04; cmd_data = 64'hC3; cmd_upd = 1'b1;
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!cmd_rdy && n < 3000) begin
            @(negedge clk);
            n++;
         end
         #1;
         check("b2b_first_rises", 64'(rise_cnt), 64'd16);
         check("b2b_first_data", cap[15:0], 64'h035A);
      end
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
      @(negedge clk);
      #1;
      check("b2b_csb_low", 64'(csb), 64'd0);
      check("b2b_gap_len", 64'(last_hi), 64'(CS_GAP + 1));
      wait_idle();
      check("b2b_second_data", cap[15:0], 64'h04C3);
      check("b2b_second_upd", 64'(upd_cyc), 64'd4);

      // ---- short write; read result must still be held ----
      send(1'b0, 5'h15, 4'd2, 64'hA55A, 1'b0);
      wait_idle();
      check("w2_rises", 64'(rise_cnt), 64'd24);
      check("w2_bits", cap[23:0], 64'h15A55A);
      check("w2_upd", 64'(upd_pulses), 64'd0);
`ifdef AD9957_SPI_READBACK_EN
      check("rsp_held", rsp_data, 64'h0040_0820);
`else
      check("rsp_tied", rsp_data, 64'd0);
`endif
      check("no_upd_while_csb_low", 64'(upd_err), 64'd0);
      check("sclk_half_width2", 64'(w_bad), 64'd0);

      // ---- reset at data bit 20 of a write ----
      send(1'b0, 5'h0E, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      begin
         int n;
         n = 0;
         while (rise_cnt < 28 && n < 3000) begin
            @(negedge clk);
            n++;
         end
         check("rst_point_reached", 64'(rise_cnt), 64'd28);
      end
      rst_n = 1'b0;
      #1;
      check("abort_csb", 64'(csb), 64'd1);
      check("abort_sclk", 64'(sclk), 64'd0);
      check("abort_busy_upd", {62'd0, busy, io_upd}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("abort_rdy_after_rel", 64'(cmd_rdy), 64'd1);
      check("abort_no_upd", 64'(upd_pulses), 64'd0);
      check("abort_no_extra_sclk", 64'(rise_cnt), 64'd28);

      // ---- len 0 and len 12 both mean 8 bytes ----
      send(1'b0, 5'h01, 4'd0, 64'hFEDC_BA98_7654_3210, 1'b0);
      wait_idle();
      check("len0_data_rises", 64'(rise_cnt - 8), 64'd64);
      check("len0_data", cap[63:0], 64'hFEDC_BA98_7654_3210);
      send(1'b0, 5'h02, 4'd12, 64'h8000_0000_0000_0001, 1'b0);
      wait_idle();
      check("len12_data_rises", 64'(rise_cnt - 8), 64'd64);
      check("len12_data", cap[71:0], 72'h02_8000_0000_0000_0001);

      // ---- global invariants ----
      check("rdy_during_busy", 64'(rdy_bad), 64'd0);
      check("sclk_while_csb_high", 64'(sclk_bad), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
